// File: rtl/idu_ctrl_pkg.sv
// rtl/idu_ctrl_pkg.sv - shared decode constants, immediate type indices and opcode classifier
package idu_ctrl_pkg;

   localparam int INST_W = 32;
   localparam int PC_W   = 32;
   localparam int IMM_W  = 32;
   localparam int TYPE_W = 6;

   localparam int TYPE_I = 1;
   localparam int TYPE_S = 2;
   localparam int TYPE_B = 3;
   localparam int TYPE_U = 4;
   localparam int TYPE_J = 5;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_REG    = 7'b0110011;

   typedef logic [TYPE_W-1:1] imm_sel_t;

   typedef enum logic [1:0] {
      ST_EMPTY,
      ST_ONE,
      ST_FULL
   } fifo_state_e;

   function automatic imm_sel_t decode_sel(input logic [6:0] op);
      imm_sel_t sel;
      sel = '0;
      case (op)
         OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM: sel[TYPE_I] = 1'b1;
         OP_STORE:                            sel[TYPE_S] = 1'b1;
         OP_BRANCH:                           sel[TYPE_B] = 1'b1;
         OP_LUI, OP_AUIPC:                    sel[TYPE_U] = 1'b1;
         OP_JAL:                              sel[TYPE_J] = 1'b1;
         default:                             sel = '0;
      endcase
      return sel;
   endfunction

   // R-type is the only recognised opcode that carries no immediate
   function automatic logic decode_illegal(input logic [6:0] op);
      return (decode_sel(op) == '0) && (op != OP_REG);
   endfunction

endpackage

// File: rtl/genImm.sv
// rtl/genImm.sv - RV32 immediate generator driven by a one-hot format select
module genImm
   import idu_ctrl_pkg::*;
(
   input  logic [INST_W-1:7] inst,
   input  imm_sel_t          imm_sel,
   output logic [IMM_W-1:0]  imm
);

   always_comb begin
      imm = '0;
      if (imm_sel[TYPE_I])
         imm = {{20{inst[31]}}, inst[31:20]};
      else if (imm_sel[TYPE_S])
         imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      else if (imm_sel[TYPE_B])
         imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      else if (imm_sel[TYPE_U])
         imm = {inst[31:12], 12'b0};
      else if (imm_sel[TYPE_J])
         imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
   end

endmodule

// File: rtl/idu_ctrl.sv
// rtl/idu_ctrl.sv - decode stage: opcode classification into a 2-entry skid FIFO toward EXU
module idu_ctrl
   import idu_ctrl_pkg::*;
(
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              flush_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [INST_W-1:0] inst_i,
   input  logic [PC_W-1:0]   pc_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [INST_W-1:0] inst_o,
   output logic [PC_W-1:0]   pc_o,
   output imm_sel_t          imm_sel_o,
   output logic [IMM_W-1:0]  imm_o,
   output logic              illegal_o
);

   fifo_state_e       state;
   logic              head;
   logic              tail;
   logic [INST_W-1:0] inst_q [2];
   logic [PC_W-1:0]   pc_q   [2];
   imm_sel_t          sel_q  [2];
   logic              ill_q  [2];

   logic push;
   logic pop;

   // ready depends only on registered state, so out_ready_i never reaches in_ready_o
   assign in_ready_o  = (state != ST_FULL);
   assign out_valid_o = (state != ST_EMPTY);
   assign push        = in_valid_i & in_ready_o;
   assign pop         = out_valid_o & out_ready_i;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state <= ST_EMPTY;
         head  <= 1'b0;
         tail  <= 1'b0;
         for (int i = 0; i < 2; i++) begin
            inst_q[i] <= '0;
            pc_q[i]   <= '0;
            sel_q[i]  <= '0;
            ill_q[i]  <= 1'b0;
         end
      end else if (flush_i) begin
         state <= ST_EMPTY;
         head  <= 1'b0;
         tail  <= 1'b0;
      end else begin
         if (push) begin
            inst_q[tail] <= inst_i;
            pc_q[tail]   <= pc_i;
            sel_q[tail]  <= decode_sel(inst_i[6:0]);
            ill_q[tail]  <= decode_illegal(inst_i[6:0]);
            tail         <= ~tail;
         end
         if (pop)
            head <= ~head;
         case (state)
            ST_EMPTY: if (push) state <= ST_ONE;
            ST_ONE: begin
               if (push && !pop)
                  state <= ST_FULL;
               else if (pop && !push)
                  state <= ST_EMPTY;
            end
            ST_FULL:  if (pop) state <= ST_ONE;
            default:  state <= ST_EMPTY;
         endcase
      end
   end

   assign inst_o    = inst_q[head];
   assign pc_o      = pc_q[head];
   assign imm_sel_o = sel_q[head];
   assign illegal_o = ill_q[head];

   genImm u_gen_imm (
      .inst    (inst_q[head][INST_W-1:7]),
      .imm_sel (sel_q[head]),
      .imm     (imm_o)
   );

endmodule

// File: tb/tb_idu_ctrl.sv
// tb/tb_idu_ctrl.sv - scoreboard bench for idu_ctrl against a queue-based reference model
module tb_idu_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] inst = '0;
   logic [31:0] pc = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] inst_o;
   logic [31:0] pc_o;
   logic [5:1]  imm_sel;
   logic [31:0] imm;
   logic        illegal;

   idu_ctrl dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .flush_i     (flush),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .inst_i      (inst),
      .pc_i        (pc),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .inst_o      (inst_o),
      .pc_o        (pc_o),
      .imm_sel_o   (imm_sel),
      .imm_o       (imm),
      .illegal_o   (illegal)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] inst;
      logic [31:0] pc;
   } beat_t;

   beat_t model [$];
   bit    flushed [logic [31:0]];
   int    n_checks = 0;
   int    n_fail = 0;
   int    n_pops = 0;
   logic [31:0] pc_cnt = 32'h8000_0000;
   logic [6:0]  ops [10];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [5:1] exp_sel(input logic [31:0] i);
      case (i[6:0])
         7'h03, 7'h13, 7'h67, 7'h73: return 5'b00001;
         7'h23:                      return 5'b00010;
         7'h63:                      return 5'b00100;
         7'h37, 7'h17:               return 5'b01000;
         7'h6F:                      return 5'b10000;
         default:                    return 5'b00000;
      endcase
   endfunction

   function automatic logic exp_ill(input logic [31:0] i);
      return (exp_sel(i) == 5'b0) && (i[6:0] != 7'h33);
   endfunction

   function automatic logic [31:0] exp_imm(input logic [31:0] i);
      int v;
      case (exp_sel(i))
         5'b00001: v = $signed(i[31:20]);
         5'b00010: v = $signed({i[31:25], i[11:7]});
         5'b00100: v = $signed({i[31], i[7], i[30:25], i[11:8]}) * 2;
         5'b01000: v = i & 32'hFFFF_F000;
         5'b10000: v = $signed({i[31], i[19:12], i[20], i[30:21]}) * 2;
         default:  v = 0;
      endcase
      return v;
   endfunction

   function automatic logic [31:0] rand_inst();
      logic [31:0] r;
      r = $urandom();
      if ($urandom_range(0, 7) == 0)
         return r;
      return {r[31:7], ops[$urandom_range(0, 9)]};
   endfunction

   // Monitor: compare the head against the model, then apply this cycle's handshakes
   always @(negedge clk) begin
      int sz;
      beat_t b;
      if (rst) begin
         chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
         chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
         chk("rst_inst", inst_o, 32'd0);
         chk("rst_pc", pc_o, 32'd0);
         chk("rst_imm", imm, 32'd0);
         chk("rst_sel_ill", {26'b0, imm_sel, illegal}, 32'd0);
         model.delete();
      end else begin
         sz = model.size();
         chk("in_ready", {31'b0, in_ready}, {31'b0, sz < 2});
         chk("out_valid", {31'b0, out_valid}, {31'b0, sz != 0});
         if (out_valid && flushed.exists(pc_o))
            chk("flushed_pc_seen", pc_o, 32'hDEAD_BEEF);
         if (out_valid && sz != 0) begin
            b = model[0];
            chk("head_pc", pc_o, b.pc);
            chk("head_inst", inst_o, b.inst);
            chk("head_sel", {27'b0, imm_sel}, {27'b0, exp_sel(b.inst)});
            chk("head_ill", {31'b0, illegal}, {31'b0, exp_ill(b.inst)});
            chk("head_imm", imm, exp_imm(b.inst));
         end
         if (flush) begin
            foreach (model[k]) flushed[model[k].pc] = 1'b1;
            if (in_valid) flushed[pc] = 1'b1;
            model.delete();
         end else begin
            if (sz != 0 && out_ready) begin
               void'(model.pop_front());
               n_pops++;
            end
            if (in_valid && sz < 2) begin
               b.inst = inst;
               b.pc   = pc;
               model.push_back(b);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] i, input logic r);
      in_valid  = v;
      inst      = i;
      pc        = pc_cnt;
      pc_cnt    = pc_cnt + 4;
      out_ready = r;
   endtask

   initial begin
      int p0;
      ops = '{7'h03, 7'h13, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33};
      #2 rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // addi x1,x0,-1 into an empty FIFO
      drive(1'b1, 32'hFFF0_0093, 1'b0);
      step();
      drive(1'b0, 32'h0, 1'b0);
      chk("addi_valid", {31'b0, out_valid}, 32'd1);
      chk("addi_sel", {27'b0, imm_sel}, 32'b00001);
      chk("addi_imm", imm, 32'hFFFF_FFFF);
      chk("addi_ill", {31'b0, illegal}, 32'd0);
      drive(1'b0, 32'h0, 1'b1);
      step();

      // sw then jal back-to-back with EXU stalled
      drive(1'b1, 32'h0011_2623, 1'b0);
      step();
      drive(1'b1, 32'h0080_00EF, 1'b0);
      step();
      drive(1'b0, 32'h0, 1'b0);
      chk("full_in_ready", {31'b0, in_ready}, 32'd0);
      chk("sw_imm", imm, 32'd12);
      chk("sw_sel", {27'b0, imm_sel}, 32'b00010);
      out_ready = 1'b1;
      step();
      chk("jal_imm", imm, 32'd8);
      chk("jal_sel", {27'b0, imm_sel}, 32'b10000);
      step();
      out_ready = 1'b0;
      chk("drained", {31'b0, out_valid}, 32'd0);

      // custom-0 opcode
      drive(1'b1, 32'h0000_000B, 1'b0);
      step();
      drive(1'b0, 32'h0, 1'b0);
      chk("cust_ill", {31'b0, illegal}, 32'd1);
      chk("cust_sel", {27'b0, imm_sel}, 32'd0);
      chk("cust_imm", imm, 32'd0);
      drive(1'b0, 32'h0, 1'b1);
      step();

      // sustained throughput starting from FULL
      drive(1'b1, rand_inst(), 1'b0);
      step();
      drive(1'b1, rand_inst(), 1'b0);
      step();
      p0 = n_pops;
      for (int k = 0; k < 100; k++) begin
         drive(1'b1, rand_inst(), 1'b1);
         step();
      end
      chk("throughput_pops", n_pops - p0, 32'd100);
      drive(1'b0, 32'h0, 1'b1);
      repeat (3) step();

      // flush while FULL with concurrent push and pop
      drive(1'b1, rand_inst(), 1'b0);
      step();
      drive(1'b1, rand_inst(), 1'b0);
      step();
      drive(1'b1, rand_inst(), 1'b1);
      flush = 1'b1;
      step();
      flush = 1'b0;
      drive(1'b0, 32'h0, 1'b0);
      chk("flush_valid", {31'b0, out_valid}, 32'd0);
      chk("flush_ready", {31'b0, in_ready}, 32'd1);
      drive(1'b1, rand_inst(), 1'b1);
      step();
      drive(1'b0, 32'h0, 1'b1);
      repeat (2) step();

      // asynchronous reset between edges while holding one entry
      drive(1'b1, rand_inst(), 1'b0);
      step();
      drive(1'b0, 32'h0, 1'b0);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_valid", {31'b0, out_valid}, 32'd0);
      chk("async_rst_ready", {31'b0, in_ready}, 32'd1);
      @(posedge clk);
      #1 rst = 1'b0;
      drive(1'b1, rand_inst(), 1'b0);
      step();
      drive(1'b0, 32'h0, 1'b0);
      chk("post_rst_push", {31'b0, out_valid}, 32'd1);

      // randomized traffic with occasional flushes
      for (int k = 0; k < 400; k++) begin
         drive($urandom_range(0, 3) != 0, rand_inst(), $urandom_range(0, 2) != 0);
         flush = ($urandom_range(0, 24) == 0);
         step();
      end
      flush = 1'b0;
      drive(1'b0, 32'h0, 1'b1);
      repeat (3) step();
      chk("final_empty", {31'b0, out_valid}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/idu_ctrl.md
IDU_CTRL -- requirements
Module: idu_ctrl

Interface
REQ-001 SHALL have no parameters; widths come from the shared `ysyx_23060251_*` macros (inst bus 32 b, imm bus `ysyx_23060251_imm`, pc bus 32 b, type field `ysyx_23060251_type` = 6).
REQ-002 SHALL have: clk_i  input  1  single clock for all state, rising edge.
REQ-003 SHALL have: rst_i  input  1  asynchronous, active-high reset.
REQ-004 SHALL have: flush_i  input  1  redirect from EXU; discards all buffered instructions.
REQ-005 SHALL have: in_valid_i  input  1  IFU beat valid.
REQ-006 SHALL have: in_ready_o  output  1  IDU can accept a beat.
REQ-007 SHALL have: inst_i  input  32  fetched instruction.
REQ-008 SHALL have: pc_i  input  32  PC of inst_i.
REQ-009 SHALL have: out_valid_o  output  1  head entry valid toward EXU.
REQ-010 SHALL have: out_ready_i  input  1  EXU accepts the head.
REQ-011 SHALL have: inst_o / pc_o  output  32 / 32  head instruction and PC.
REQ-012 SHALL have: imm_sel_o  output  [type-1:1]  one-hot immediate type, bits 1..5 = I, S, B, U, J; all-zero = none (R-type).
REQ-013 SHALL have: imm_o  output  imm bus  immediate of the head instruction.
REQ-014 SHALL have: illegal_o  output  1  head opcode unrecognised.

Function
REQ-015 Opcode decode on inst_i[6:0] at enqueue: 0000011, 0010011, 1100111, 1110011 -> I; 0100011 -> S; 1100011 -> B; 0110111, 0010111 -> U; 1101111 -> J; 0110011 -> none.
REQ-016 Any other opcode, including inst_i[1:0] != 2'b11 -> imm_sel zero and illegal = 1.
REQ-017 Storage: 2-entry FIFO of {inst, pc, imm_sel, illegal}; states EMPTY, ONE, FULL.
REQ-018 Push = in_valid_i & in_ready_o; pop = out_valid_o & out_ready_i.
REQ-019 Transitions: EMPTY+push -> ONE; ONE+push only -> FULL; ONE+pop only -> EMPTY; ONE+push+pop -> ONE; FULL+pop -> ONE.
REQ-020 in_ready_o = (state != FULL), a function of registered state only; there is no combinational path from out_ready_i.
REQ-021 out_valid_o = (state != EMPTY).
REQ-022 Outputs are driven from the head entry and held stable while out_valid_o & !out_ready_i.
REQ-023 Latency: a beat pushed in cycle N is visible at the head in cycle N+1 when the FIFO was EMPTY.
REQ-024 Throughput: 1 instruction per cycle sustained.
REQ-025 imm_o is generated combinationally from head inst and head imm_sel; imm_o = 0 when imm_sel is zero.
REQ-026 Head/tail pointers are 1 bit each and wrap modulo 2.
REQ-027 flush_i has priority over push and pop in the same cycle: the state goes to EMPTY next cycle and the concurrent incoming beat is discarded.
REQ-028 EXU ignores a pop that coincides with flush_i; the popped instruction is not retried.

Reset
REQ-029 rst_i asserted, asynchronously: state = EMPTY and pointers = 0, giving out_valid_o = 0 and in_ready_o = 1.
REQ-030 On reset, data registers are cleared to 0, so inst_o, pc_o, imm_sel_o and illegal_o = 0 and imm_o = 0.
REQ-031 Reset mid-transfer drops all entries; the first push is accepted in the first clk_i edge after rst_i deasserts.

Structure
REQ-032 Opcode localparams and the one-hot type bit indices SHALL live in the shared core defines/package, not locally.
REQ-033 The one natural sub-module SHALL be the immediate generator genImm, instantiated once on the head entry.

Verification
REQ-034 Push 0xFFF00093 (addi x1,x0,-1) into EMPTY -> next cycle out_valid_o=1, imm_sel_o=5'b00001, imm_o=0xFFFFFFFF, illegal_o=0.
REQ-035 Push 0x00112623 (sw) then 0x008000EF (jal) back-to-back with out_ready_i=0 -> state FULL, in_ready_o=0; then two pops return S imm 12, then J imm 8, in order.
REQ-036 Hold FULL with out_ready_i=1 and in_valid_i=1 -> one pop per cycle; in_ready_o=1 from the cycle after the first pop; no drop and no duplicate over 100 random instructions.
REQ-037 Push 0x0000000B (custom-0) -> illegal_o=1, imm_sel_o=0, imm_o=0.
REQ-038 Assert flush_i with state FULL and push and pop in the same cycle -> next cycle out_valid_o=0, in_ready_o=1, and the flushed PCs never appear at pc_o.
REQ-039 Assert rst_i asynchronously between clock edges while in state ONE -> out_valid_o falls before the next clk_i edge.
